// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result word format.
// Words carry 15 data bits in [15:1] and odd parity in bit 0.
package alu_pkg;
  localparam int DATA_W = 15;
  localparam int WORD_W = 16;
  localparam logic [DATA_W-1:0] NEG_ZERO = 15'h7FFF;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    AD   = 3'd0,
    SU   = 3'd1,
    MASK = 3'd2,
    MP0  = 3'd3,
    MP1  = 3'd4,
    DV0  = 3'd5,
    DV1  = 3'd6
  } alu_op_e;

  // Parity bit makes the total count of ones in the word odd.
  function automatic word_t encode_word(input logic [DATA_W-1:0] d);
    return {d, ~^d};
  endfunction
endpackage

// File: rtl/word_fifo.sv
// Generic synchronous FIFO with synchronous clear.
// Full/empty come from the occupancy counter; pointers wrap naturally.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      do_push = push && (occ_q != DEPTH_C);
      do_pop  = pop && (occ_q != '0);
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        occ_d = occ_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        occ_d = occ_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign occupancy = occ_q;
  assign full      = (occ_q == DEPTH_C);
  assign empty     = (occ_q == '0);
endmodule

// File: rtl/alu_result_writer.sv
// Encodes ALU one's-complement results into parity-protected words and
// buffers them for write-back, with delivery count and sticky -0 flag.
module alu_result_writer
  import alu_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter bit NORM_NEG_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_valid,
  input  logic [DATA_W-1:0]      res_data,
  output logic                   res_ready,
  output logic                   word_valid,
  output logic [WORD_W-1:0]      word_data,
  input  logic                   word_ready,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            word_count,
  output logic                   neg_zero_seen
);
  logic              push, pop, full, empty;
  logic [DATA_W-1:0] data_norm;
  word_t             enc_word;
  logic [15:0]       word_count_q, word_count_d;
  logic              neg_zero_q, neg_zero_d;

  assign res_ready  = !full;
  assign word_valid = !empty;
  assign push       = res_valid && res_ready;
  assign pop        = word_valid && word_ready;

  always_comb begin
    data_norm    = (NORM_NEG_ZERO && (res_data == NEG_ZERO)) ? '0 : res_data;
    enc_word     = encode_word(data_norm);
    word_count_d = word_count_q;
    neg_zero_d   = neg_zero_q;
    if (clear) begin
      word_count_d = '0;
      neg_zero_d   = 1'b0;
    end else begin
      if (pop) word_count_d = word_count_q + 16'd1;
      // Flag reflects the raw input, independent of normalization.
      if (push && (res_data == NEG_ZERO)) neg_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= '0;
      neg_zero_q   <= 1'b0;
    end else begin
      word_count_q <= word_count_d;
      neg_zero_q   <= neg_zero_d;
    end
  end

  word_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .wr_data  (enc_word),
    .rd_data  (word_data),
    .occupancy(occupancy),
    .full     (full),
    .empty    (empty)
  );

  assign word_count    = word_count_q;
  assign neg_zero_seen = neg_zero_q;
endmodule

// File: tb/tb_alu_result_writer.sv
// Randomized and directed bench for alu_result_writer against a queue model.
module tb_alu_result_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [14:0] res_data = '0;
  logic        word_ready = 1'b0;
  logic        clear = 1'b0;

  logic        res_ready_1, word_valid_1, neg_zero_1;
  logic [15:0] word_data_1, word_count_1;
  logic [2:0]  occupancy_1;
  logic        res_ready_0, word_valid_0, neg_zero_0;
  logic [15:0] word_data_0, word_count_0;
  logic [2:0]  occupancy_0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] q[$];
  int          exp_count = 0;
  bit          exp_nz = 1'b0;
  bit          acc;

  always #5 clk = ~clk;

  alu_result_writer #(.DEPTH(4), .NORM_NEG_ZERO(1'b1)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready_1), .word_valid(word_valid_1), .word_data(word_data_1),
    .word_ready(word_ready), .clear(clear), .occupancy(occupancy_1),
    .word_count(word_count_1), .neg_zero_seen(neg_zero_1)
  );

  alu_result_writer #(.DEPTH(4), .NORM_NEG_ZERO(1'b0)) u_dut_n0 (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready_0), .word_valid(word_valid_0), .word_data(word_data_0),
    .word_ready(word_ready), .clear(clear), .occupancy(occupancy_0),
    .word_count(word_count_0), .neg_zero_seen(neg_zero_0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Odd total parity: bit 0 set when the data field has an even number of ones.
  function automatic logic [15:0] enc(input logic [14:0] d, input bit norm);
    logic [14:0] v;
    v = (norm && d == 15'h7FFF) ? 15'h0000 : d;
    return {v, ($countones(v) % 2 == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic check_outputs();
    check_eq("res_ready",  res_ready_1,  q.size() < 4);
    check_eq("word_valid", word_valid_1, q.size() != 0);
    check_eq("occupancy",  occupancy_1,  q.size());
    check_eq("word_count", word_count_1, exp_count[15:0]);
    check_eq("neg_zero",   neg_zero_1,   exp_nz);
    check_eq("n0_occ",     occupancy_0,  q.size());
    check_eq("n0_neg_zero", neg_zero_0,  exp_nz);
    check_eq("n0_count",   word_count_0, exp_count[15:0]);
    if (q.size() != 0) begin
      check_eq("word_data",    word_data_1, enc(q[0], 1'b1));
      check_eq("n0_word_data", word_data_0, enc(q[0], 1'b0));
    end
  endtask

  // One clock: drive, check current outputs against the model, advance model.
  task automatic tick(input bit v, input logic [14:0] d, input bit wr, input bit clr,
                      output bit accepted);
    bit pop_e;
    res_valid  = v;
    res_data   = v ? d : 15'bx;
    word_ready = wr;
    clear      = clr;
    #0;
    check_outputs();
    accepted = v && (q.size() < 4) && !clr;
    pop_e    = wr && (q.size() != 0);
    if (clr) begin
      q.delete();
      exp_count = 0;
      exp_nz    = 1'b0;
    end else begin
      if (pop_e) begin
        void'(q.pop_front());
        exp_count = (exp_count + 1) % 65536;
      end
      if (accepted) begin
        q.push_back(d);
        if (d == 15'h7FFF) exp_nz = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("drain_empty", word_valid_1, 1'b0);
  endtask

  initial begin
    #12;
    check_eq("rst_ready", res_ready_1, 1'b1);
    check_eq("rst_valid", word_valid_1, 1'b0);
    check_eq("rst_data",  word_data_1, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ordered pushes with immediate consumption.
    tick(1'b1, 15'd8, 1'b1, 1'b0, acc);
    check_eq("lat_valid", word_valid_1, 1'b1);
    check_eq("w8", word_data_1, 16'h0010);
    tick(1'b1, 15'd3, 1'b1, 1'b0, acc);
    check_eq("w3", word_data_1, 16'h0007);
    tick(1'b1, 15'd153, 1'b1, 1'b0, acc);
    check_eq("w153", word_data_1, 16'h0133);
    tick(1'b0, '0, 1'b1, 1'b0, acc);
    check_eq("count3", word_count_1, 16'd3);

    // Negative zero on both normalization settings.
    tick(1'b1, 15'h7FFF, 1'b0, 1'b0, acc);
    check_eq("nz_word_n1", word_data_1, 16'h0001);
    check_eq("nz_word_n0", word_data_0, 16'hFFFE);
    check_eq("nz_flag", neg_zero_1, 1'b1);
    drain();

    // Fill with consumer stalled; fifth value held by the source.
    for (int v = 1; v <= 4; v++) tick(1'b1, 15'(v), 1'b0, 1'b0, acc);
    check_eq("full_ready", res_ready_1, 1'b0);
    check_eq("full_occ", occupancy_1, 3'd4);
    tick(1'b1, 15'd5, 1'b0, 1'b0, acc);
    tick(1'b1, 15'd5, 1'b1, 1'b0, acc);
    check_eq("full_pop_occ", occupancy_1, 3'd3);
    tick(1'b1, 15'd5, 1'b1, 1'b0, acc);
    check_eq("push_after_pop_occ", occupancy_1, 3'd3);
    drain();

    // Clear beats push and pop in the same cycle.
    tick(1'b1, 15'h7FFF, 1'b0, 1'b0, acc);
    tick(1'b1, 15'd77, 1'b0, 1'b0, acc);
    tick(1'b1, 15'd99, 1'b1, 1'b1, acc);
    check_eq("clr_occ", occupancy_1, 3'd0);
    check_eq("clr_valid", word_valid_1, 1'b0);
    check_eq("clr_count", word_count_1, 16'd0);
    check_eq("clr_nz", neg_zero_1, 1'b0);

    // Async reset between edges while a burst is in flight.
    tick(1'b1, 15'd21, 1'b0, 1'b0, acc);
    tick(1'b1, 15'h7FFF, 1'b1, 1'b0, acc);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", res_ready_1, 1'b1);
    check_eq("arst_valid", word_valid_1, 1'b0);
    check_eq("arst_data",  word_data_1, 16'h0000);
    check_eq("arst_occ",   occupancy_1, 3'd0);
    check_eq("arst_count", word_count_1, 16'd0);
    check_eq("arst_nz",    neg_zero_1, 1'b0);
    q.delete();
    exp_count = 0;
    exp_nz    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 15'd8, 1'b0, 1'b0, acc);
    check_eq("post_rst_w8", word_data_1, 16'h0010);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [14:0] d;
      d = ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom);
      tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0, acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_writer.md
# alu_result_writer

Converts 15-bit one's-complement results from `ALU` into 16-bit memory/operand words, with odd parity in bit 0 (data in [15:1]). It is the write-back end of the operand format that `ALU` consumes on `A`/`B`. It buffers results in a small FIFO with valid/ready handshakes on both sides. It optionally normalizes negative zero and keeps sticky status for the bench and the sequencer.

## Interface
- `DEPTH`, 4: FIFO entries; a power of two, 2..16.
- `NORM_NEG_ZERO`, 1: when 1, rewrite -0 (15'h7FFF) as +0 before encoding.
- `clk` input 1: sole clock; rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `res_valid` input 1: `res_data` holds a result to write.
- `res_data` input 15: ALU result (one's complement).
- `res_ready` output 1: writer can accept a result this cycle.
- `word_valid` output 1: `word_data` is valid.
- `word_data` output 16: {data[14:0], parity}.
- `word_ready` input 1: consumer takes the word this cycle.
- `clear` input 1: synchronous flush of FIFO, counters and flags.
- `occupancy` output $clog2(DEPTH)+1: current entry count.
- `word_count` output 16: words delivered since reset/clear; wraps 16'hFFFF→0.
- `neg_zero_seen` output 1: sticky; any accepted input equalled 15'h7FFF.

## Operation
- Push when `res_valid && res_ready`. Pop when `word_valid && word_ready`.
- Encoding at push: d = (NORM_NEG_ZERO && res_data==15'h7FFF) ? 15'h0000 : res_data. Then parity = ~^d, so the 16-bit word has an odd number of ones. Stored word = {d, parity}.
- `res_ready` = (occupancy < DEPTH). It depends on registered state only; no combinational path from `word_ready`.
- Full with a pop in the same cycle: `res_ready` is still 0, so the push is refused. Empty: a push is not visible on `word_valid` until the next cycle; there is no bypass.
- Simultaneous push and pop when 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. The full/empty decision comes from the occupancy counter.
- `word_valid` = (occupancy != 0). `word_data` = entry at the read pointer. It holds stable while `word_valid && !word_ready`.
- `word_count` increments on every pop. `neg_zero_seen` sets on an accepted push of 15'h7FFF, whatever NORM_NEG_ZERO is.
- `clear` has priority over push and pop in the same cycle. It resets pointers, occupancy, `word_count` and `neg_zero_seen`. Data held in the clear cycle is discarded.
- X on `res_data` while `res_valid`=0 has no effect.

## Timing
- Reset values, asynchronous on `rst_n` low: `res_ready`=1, `word_valid`=0, `word_data`=16'h0000, `occupancy`=0, `word_count`=0, `neg_zero_seen`=0. FIFO storage is also cleared.
- Latency: a push in cycle N into an empty FIFO gives `word_valid`=1 in cycle N+1.
- Throughput: 1 word/cycle sustained when `word_ready` is held high.
- `rst_n` low mid-transfer drops every entry at once. The first push is accepted on the first clock edge after `rst_n` rises.
- Outputs are registers or decodes of registers only.

## Structure
- The shared package `alu_pkg` holds: `DATA_W`=15 and `WORD_W`=16, `NEG_ZERO`=15'h7FFF, the word type, and the ALU opcode constants (AD, SU, MASK, MP0, MP1, DV0, DV1).
- Sub-module `word_fifo` is a generic synchronous FIFO with DEPTH×WORD_W storage, occupancy and clear. The top level holds the encoder, the flags and `word_count`.

## Test plan
- DEPTH=4, NORM=1; push 15'd8, then 15'd3, then 15'd153 with `word_ready`=1 → words 16'h0010, 16'h0007, 16'h0133 in order, one cycle after each push; `word_count`=3.
- NORM=1: push 15'h7FFF → word 16'h0001 and `neg_zero_seen`=1. Repeat with NORM=0 → word 16'hFFFE and `neg_zero_seen`=1.
- `word_ready`=0; push 5 values 1..5 back to back → `res_ready` drops after the 4th push and `occupancy`=4. The 5th value is held by the source until `word_ready` goes high, then all 5 drain in order.
- Full FIFO with `word_ready`=1 and `res_valid`=1 in the same cycle → pop only; `occupancy` goes 4→3; the push is accepted the next cycle.
- Occupancy 2 with `clear`=1, `res_valid`=1 and `word_ready`=1 → next cycle `occupancy`=0, `word_valid`=0, `word_count`=0, flags cleared.
- Assert `rst_n` low asynchronously mid-burst (between edges) → outputs take their reset values immediately; after release, 15'd8 is written as 16'h0010.
